// File: rtl/mem_req_arbiter_pkg.sv
// Shared defaults and encodings for the memory request arbiter.
// Default widths match the mem_controller array and memory/VPI port.
package mem_req_arbiter_pkg;

    localparam int unsigned DEF_CONTROLLERS_WIDTH = 2;
    localparam int unsigned DEF_DATA_WIDTH        = 32;
    localparam int unsigned DEF_ADDR_WIDTH        = 31;
    localparam int unsigned DEF_TID_WIDTH         = 16;
    localparam int unsigned DEF_OUTSTANDING       = 4;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ISSUE = 1'b1;

    // A one-requester index still needs a 1-bit field.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/arb_tag_fifo.sv
// Small synchronous FIFO holding the source index of each issued request.
// Wrap-around pointers; DEPTH must be a power of two.
module arb_tag_fifo
    import mem_req_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_OUTSTANDING,
    parameter int unsigned WIDTH = 1,
    localparam int unsigned PW   = $clog2(DEPTH),
    localparam int unsigned CNTW = PW + 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic [CNTW-1:0]  o_count,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CNTW-1:0]  r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CNTW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNTW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNTW'(1);
            end
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter sharing one memory/VPI port among per-controller FIFO pairs.
// Responses return in issue order and are steered by a FIFO of source indices.
module mem_req_arbiter
    import mem_req_arbiter_pkg::*;
#(
    parameter int unsigned CONTROLLERS_WIDTH = DEF_CONTROLLERS_WIDTH,
    parameter int unsigned DATA_WIDTH        = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH        = DEF_ADDR_WIDTH,
    parameter int unsigned TID_WIDTH         = DEF_TID_WIDTH,
    parameter int unsigned REQ_WIDTH         = 1 + ADDR_WIDTH + DATA_WIDTH,
    parameter int unsigned DP_DATA_WIDTH     = TID_WIDTH + REQ_WIDTH,
    parameter int unsigned VPI_DATA_WIDTH    = TID_WIDTH + DATA_WIDTH,
    parameter int unsigned OUTSTANDING       = DEF_OUTSTANDING
) (
    input  logic                                      i_clk,
    input  logic                                      i_reset,
    output logic [CONTROLLERS_WIDTH-1:0]              o_read_ctr_pack,
    input  logic [DP_DATA_WIDTH*CONTROLLERS_WIDTH-1:0]  i_data_in_pack,
    input  logic [CONTROLLERS_WIDTH-1:0]              i_empty_flag_pack,
    output logic [CONTROLLERS_WIDTH-1:0]              o_write_ctr_pack,
    output logic [VPI_DATA_WIDTH*CONTROLLERS_WIDTH-1:0] o_data_out_pack,
    input  logic [CONTROLLERS_WIDTH-1:0]              i_full_flag_pack,
    output logic                                      o_mem_req_valid,
    input  logic                                      i_mem_req_ready,
    output logic [DP_DATA_WIDTH-1:0]                  o_mem_req_data,
    input  logic                                      i_mem_rsp_valid,
    output logic                                      o_mem_rsp_ready,
    input  logic [VPI_DATA_WIDTH-1:0]                 i_mem_rsp_data,
    output logic                                      o_proto_err
);

    localparam int unsigned IDXW = idx_width(CONTROLLERS_WIDTH);
    localparam int unsigned CNTW = $clog2(OUTSTANDING) + 1;

    logic [0:0]               r_state;
    logic [DP_DATA_WIDTH-1:0] r_req_data;
    logic [IDXW-1:0]          r_rr_ptr;
    logic                     r_proto_err;

    logic                     w_found;
    logic [IDXW-1:0]          w_grant;
    logic [IDXW-1:0]          w_cand;
    logic [DP_DATA_WIDTH-1:0] w_grant_data;
    logic                     w_slot_free;
    logic                     w_can_grant;
    logic                     w_rsp_fire;
    logic [IDXW-1:0]          w_tag_head;
    logic [CNTW-1:0]          w_tag_count;
    logic                     w_tag_full;
    logic                     w_tag_empty;

    // Search rr_ptr, rr_ptr+1, ... for the first non-empty request FIFO.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_cand  = '0;
        for (int unsigned k = 0; k < CONTROLLERS_WIDTH; k++) begin
            w_cand = IDXW'((32'(r_rr_ptr) + k) % CONTROLLERS_WIDTH);
            if (!w_found && !i_empty_flag_pack[w_cand]) begin
                w_found = 1'b1;
                w_grant = w_cand;
            end
        end
    end

    always_comb begin
        w_grant_data = '0;
        for (int unsigned i = 0; i < CONTROLLERS_WIDTH; i++) begin
            if (w_grant == IDXW'(i)) begin
                w_grant_data = i_data_in_pack[i*DP_DATA_WIDTH +: DP_DATA_WIDTH];
            end
        end
    end

    // Full tag FIFO blocks the grant even if a response pops it this cycle.
    assign w_slot_free     = (r_state == ST_IDLE) || i_mem_req_ready;
    assign w_can_grant     = !i_reset && w_slot_free && w_found && !w_tag_full;
    assign o_mem_rsp_ready = !i_reset && (w_tag_count != '0) && !i_full_flag_pack[w_tag_head];
    assign w_rsp_fire      = i_mem_rsp_valid && o_mem_rsp_ready;

    always_comb begin
        o_read_ctr_pack  = '0;
        o_write_ctr_pack = '0;
        o_data_out_pack  = '0;
        for (int unsigned i = 0; i < CONTROLLERS_WIDTH; i++) begin
            o_read_ctr_pack[i]  = w_can_grant && (w_grant == IDXW'(i));
            o_write_ctr_pack[i] = w_rsp_fire && (w_tag_head == IDXW'(i));
            o_data_out_pack[i*VPI_DATA_WIDTH +: VPI_DATA_WIDTH] = i_mem_rsp_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_req_data  <= '0;
            r_rr_ptr    <= '0;
            r_proto_err <= 1'b0;
        end else begin
            if (w_can_grant) begin
                r_state    <= ST_ISSUE;
                r_req_data <= w_grant_data;
                r_rr_ptr   <= (w_grant == IDXW'(CONTROLLERS_WIDTH - 1)) ? '0
                                                                         : w_grant + IDXW'(1);
            end else if ((r_state == ST_ISSUE) && i_mem_req_ready) begin
                r_state <= ST_IDLE;
            end
            if (i_mem_rsp_valid && w_tag_empty) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    assign o_mem_req_valid = (r_state == ST_ISSUE);
    assign o_mem_req_data  = r_req_data;
    assign o_proto_err     = r_proto_err;

    arb_tag_fifo #(
        .DEPTH (OUTSTANDING),
        .WIDTH (IDXW)
    ) u_tag_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (w_can_grant),
        .i_data  (w_grant),
        .i_pop   (w_rsp_fire),
        .o_head  (w_tag_head),
        .o_count (w_tag_count),
        .o_full  (w_tag_full),
        .o_empty (w_tag_empty)
    );

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: a cycle table plus hand-written corner sequences.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_mem_req_arbiter;

    localparam int CW   = 2;
    localparam int DPW  = 16 + 1 + 31 + 32;
    localparam int VPW  = 16 + 32;

    logic              clk = 1'b0;
    logic              reset;
    logic [CW-1:0]     read_ctr;
    logic [DPW*CW-1:0] data_in;
    logic [CW-1:0]     empty;
    logic [CW-1:0]     write_ctr;
    logic [VPW*CW-1:0] data_out;
    logic [CW-1:0]     full;
    logic              req_valid;
    logic              req_ready;
    logic [DPW-1:0]    req_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [VPW-1:0]    rsp_data;
    logic              proto_err;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [DPW-1:0] HEAD0 = {16'd5, 1'b1, 31'd15, 32'd7};
    localparam logic [DPW-1:0] HEAD1 = {16'd9, 1'b0, 31'h20, 32'h1234};

    always #5 clk = ~clk;

    mem_req_arbiter u_dut (
        .i_clk             (clk),
        .i_reset           (reset),
        .o_read_ctr_pack   (read_ctr),
        .i_data_in_pack    (data_in),
        .i_empty_flag_pack (empty),
        .o_write_ctr_pack  (write_ctr),
        .o_data_out_pack   (data_out),
        .i_full_flag_pack  (full),
        .o_mem_req_valid   (req_valid),
        .i_mem_req_ready   (req_ready),
        .o_mem_req_data    (req_data),
        .i_mem_rsp_valid   (rsp_valid),
        .o_mem_rsp_ready   (rsp_ready),
        .i_mem_rsp_data    (rsp_data),
        .o_proto_err       (proto_err)
    );

    typedef struct packed {
        logic [1:0] empty;
        logic       ready;
        logic       rspv;
        logic [1:0] full;
        logic [1:0] rd;
        logic [1:0] wr;
        logic       valid;
        logic       rsprdy;
        logic       perr;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        empty     = '1;
        full      = '0;
        req_ready = 1'b1;
        rsp_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int grants;

        // Cycle table starting right after reset; registered outputs reflect the prior edge.
        //            empty  rdy  rspv full   rd     wr     vld  rrdy perr
        vecs[0]  = '{2'b11, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{2'b10, 1'b1, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{2'b11, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{2'b11, 1'b1, 1'b1, 2'b00, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{2'b00, 1'b1, 1'b0, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{2'b00, 1'b1, 1'b0, 2'b00, 2'b01, 2'b00, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{2'b00, 1'b1, 1'b1, 2'b00, 2'b10, 2'b10, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{2'b00, 1'b1, 1'b1, 2'b01, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{2'b11, 1'b0, 1'b1, 2'b00, 2'b00, 2'b01, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{2'b11, 1'b1, 1'b1, 2'b10, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{2'b11, 1'b1, 1'b1, 2'b00, 2'b00, 2'b10, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{2'b11, 1'b1, 1'b1, 2'b00, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{2'b11, 1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{2'b11, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1};

        data_in   = {HEAD1, HEAD0};
        rsp_data  = {16'd5, 32'hAB};
        reset     = 1'b1;
        empty     = '0;
        full      = '0;
        req_ready = 1'b1;
        rsp_valid = 1'b0;
        @(negedge clk);

        // Reset with both request FIFOs non-empty: no pops, all outputs low.
        for (int c = 0; c < 2; c++) begin
            #1;
            check("reset_read_ctr", read_ctr, 2'b00);
            check("reset_write_ctr", write_ctr, 2'b00);
            check("reset_rsp_ready", rsp_ready, 1'b0);
            @(negedge clk);
        end
        #1;
        check("reset_req_valid", req_valid, 1'b0);
        check("reset_req_data", req_data, '0);
        check("reset_proto_err", proto_err, 1'b0);

        // Single request from ctrl0 and its response.
        reset = 1'b0;
        empty = 2'b10;
        #1;
        check("first_grant", read_ctr, 2'b01);
        @(negedge clk);
        empty = 2'b11;
        #1;
        check("single_valid", req_valid, 1'b1);
        check("single_data", req_data, HEAD0);
        check("single_no_pop", read_ctr, 2'b00);
        @(negedge clk);
        rsp_valid = 1'b1;
        #1;
        check("single_write_ctr", write_ctr, 2'b01);
        check("single_data_out0", data_out[VPW-1:0], {16'd5, 32'hAB});
        check("single_data_out1", data_out[2*VPW-1:VPW], {16'd5, 32'hAB});
        @(negedge clk);
        rsp_valid = 1'b0;
        #1;
        check("single_drained", rsp_ready, 1'b0);
        check("single_no_err", proto_err, 1'b0);

        do_reset();
        for (int i = 0; i < 14; i++) begin
            empty     = vecs[i].empty;
            req_ready = vecs[i].ready;
            rsp_valid = vecs[i].rspv;
            full      = vecs[i].full;
            #1;
            check($sformatf("vec%0d_read_ctr", i), read_ctr, vecs[i].rd);
            check($sformatf("vec%0d_write_ctr", i), write_ctr, vecs[i].wr);
            check($sformatf("vec%0d_req_valid", i), req_valid, vecs[i].valid);
            check($sformatf("vec%0d_rsp_ready", i), rsp_ready, vecs[i].rsprdy);
            check($sformatf("vec%0d_proto_err", i), proto_err, vecs[i].perr);
            @(negedge clk);
        end
        rsp_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("proto_err_sticky", proto_err, 1'b1);
            @(negedge clk);
        end
        do_reset();
        #1;
        check("proto_err_cleared", proto_err, 1'b0);

        // Fairness: both always non-empty, each response returned the cycle after issue.
        empty = 2'b00;
        for (int n = 0; n < 8; n++) begin
            rsp_valid = (n >= 1);
            #1;
            check($sformatf("fair_grant%0d", n), read_ctr, (n % 2 == 0) ? 2'b01 : 2'b10);
            if (n >= 1) begin
                check($sformatf("fair_rsp%0d", n), write_ctr, (n % 2 == 1) ? 2'b01 : 2'b10);
            end
            @(negedge clk);
        end
        empty = 2'b11;
        #1;
        check("fair_last_rsp", write_ctr, 2'b10);
        @(negedge clk);
        rsp_valid = 1'b0;
        #1;
        check("fair_no_err", proto_err, 1'b0);

        // Request backpressure: held word stays put, no pops until ready.
        do_reset();
        empty     = 2'b10;
        req_ready = 1'b0;
        #1;
        check("bp_first_grant", read_ctr, 2'b01);
        @(negedge clk);
        empty = 2'b00;
        for (int c = 0; c < 5; c++) begin
            #1;
            check($sformatf("bp_valid%0d", c), req_valid, 1'b1);
            check($sformatf("bp_data%0d", c), req_data, HEAD0);
            check($sformatf("bp_no_pop%0d", c), read_ctr, 2'b00);
            @(negedge clk);
        end
        req_ready = 1'b1;
        #1;
        check("bp_regrant", read_ctr, 2'b10);
        @(negedge clk);
        #1;
        check("bp_next_valid", req_valid, 1'b1);
        check("bp_next_data", req_data, HEAD1);

        // Outstanding limit: four issues, then one more per response.
        do_reset();
        empty  = 2'b00;
        grants = 0;
        for (int c = 0; c < 8; c++) begin
            #1;
            grants += $countones(read_ctr);
            @(negedge clk);
        end
        check("outstanding_grants", grants, 4);
        rsp_valid = 1'b1;
        #1;
        check("outstanding_rsp", write_ctr, 2'b01);
        check("outstanding_no_same_cycle", read_ctr, 2'b00);
        @(negedge clk);
        rsp_valid = 1'b0;
        grants    = 0;
        for (int c = 0; c < 4; c++) begin
            #1;
            grants += $countones(read_ctr);
            @(negedge clk);
        end
        check("outstanding_one_more", grants, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
